l1_mmu_arbiter: RTL and testbench
=================================

# l1_mmu_arbiter

Arbitrates the single l1mmu line port between the L1 instruction cache and the L1 data cache, replacing the combinational i-cache-wins mux in the top level. It grants one requester at a time with round-robin fairness, latches that requester's address and write line, and holds them stable to l1mmu for the whole transaction. It routes the done pulse and read line back to the owner only. A watchdog flags a stuck MMU transaction.

## Interface
- ADDR_W, 32, address width
- LINE_W, 256, cache line width in bits
- TIMEOUT, 1024, cycles waiting on mmu_done before timeout_err sets (≥2)

- sys_clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- ic_read  in  1  i-cache line read request; level, held until ic_done seen
- ic_addr  in  ADDR_W  i-cache line address
- ic_done  out  1  one-cycle completion pulse to i-cache
- ic_read_data  out  LINE_W  line returned to i-cache, valid with ic_done
- dc_read  in  1  d-cache line read request; level
- dc_write  in  1  d-cache line write-back request; level
- dc_addr  in  ADDR_W  d-cache line address
- dc_write_data  in  LINE_W  d-cache write-back line
- dc_done  out  1  one-cycle completion pulse to d-cache
- dc_read_data  out  LINE_W  line returned to d-cache, valid with dc_done
- mmu_read  out  1  read request to l1mmu
- mmu_write  out  1  write request to l1mmu
- mmu_addr  out  ADDR_W  latched address to l1mmu
- mmu_write_data  out  LINE_W  latched write line to l1mmu
- mmu_done  in  1  l1mmu completion pulse
- mmu_read_data  in  LINE_W  l1mmu read line, valid with mmu_done
- owner  out  2  status: 00 none, 01 i-cache, 10 d-cache
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Register last_grant (I/D) drives fairness.
- IDLE: the arbiter evaluates requests. A d-cache request is dc_read|dc_write.
  - Only ic_read → GRANT_I.
  - Only a d-cache request → GRANT_D.
  - Both → the side not equal to last_grant wins.
  - Entering a grant state latches the winner's address into mmu_addr and sets last_grant.
  - For D it also latches dc_write_data into mmu_write_data.
- GRANT_I: mmu_read=1, mmu_write=0, owner=01.
- GRANT_D: mmu_write=latched dc_write, mmu_read=latched dc_read & ~dc_write, owner=10.
  - dc_read and dc_write together is treated as a write.
- In a grant state, mmu_done → RELEASE.
  - The owner's done registers high for the next cycle.
  - Its read_data register captures mmu_read_data.
  - The other requester's done and read_data are untouched.
- RELEASE: mmu_read and mmu_write are 0, owner=00. The next state is always IDLE.
  - This absorbs the cycle in which the requester still presents its stale request.
- Requests that change while granted are ignored; latched values stay stable until mmu_done.
- mmu_done in IDLE or RELEASE is ignored.
- Watchdog counter:
  - Clears on entry to each grant state and increments each granted cycle without mmu_done.
  - Reaching TIMEOUT sets timeout_err, which holds until reset. The counter saturates.
  - The transaction keeps waiting; it is not aborted.

## Timing
- Reset (async assert, any state, mid-transaction included): state IDLE, last_grant=D (first tie goes to I).
  - Outputs: all mmu_* 0, ic_done/dc_done 0, ic_read_data/dc_read_data 0, owner 00, timeout_err 0, watchdog 0.
  - Any in-flight transaction is dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A request sampled high in IDLE at edge N produces the MMU request in cycle N+1.
- mmu_done sampled at edge K:
  - The done pulse and data appear in cycle K+1, for exactly one cycle.
  - mmu request is low from K+1.
  - IDLE is reached at K+2, where the next arbitration is sampled.
- Minimum turnaround from one mmu_done to the next MMU request is 3 cycles.
- mmu_done in the first granted cycle is legal.
- Continuous requests from both sides alternate I, D, I, D…; neither side waits more than one transaction.

## Test plan
- Reset, then ic_read=1, ic_addr=0x0000_0040. MMU returns done after 4 cycles with data 0xAA…AA.
  - Required: mmu_read high for exactly 4 cycles, mmu_addr=0x40, one ic_done pulse with ic_read_data=0xAA…AA, dc_done never high.
- ic_read and dc_read both high from reset, held, MMU done after 2 cycles each.
  - Required: grant order I, D, I, D; owner alternates 01/10 with 00 between grants.
- dc_write=1, dc_addr=0x100, dc_write_data=0x55…55. Change dc_addr to 0x200 while granted.
  - Required: mmu_write=1, mmu_read=0, mmu_addr remains 0x100 until done, then one dc_done pulse.
- mmu_done pulsed while IDLE, then ic_read raised.
  - Required: no done to either side; normal I transaction follows.
- Reset asserted mid-GRANT_D.
  - Required: mmu_write, owner and dc_done are 0 immediately.
  - After release, a simultaneous I and D request grants I first.
- TIMEOUT=8, grant I, never assert mmu_done.
  - Required: timeout_err rises on the 8th granted cycle and stays high.
  - A later mmu_done still completes with ic_done; timeout_err stays 1 until reset.

Source files
------------

// File: rtl/l1_mmu_arbiter.sv
// Round-robin arbiter for the shared l1mmu line port (i-cache vs d-cache).
// Latches the winner's request, routes done/data back to the owner, and flags stuck transactions.
module l1_mmu_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_read_data,
    output logic              mmu_read,
    output logic              mmu_write,
    output logic [ADDR_W-1:0] mmu_addr,
    output logic [LINE_W-1:0] mmu_write_data,
    input  logic              mmu_done,
    input  logic [LINE_W-1:0] mmu_read_data,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_last_d;
    logic [WD_W-1:0] r_wdog;

    logic w_dc_req;
    logic w_pick_i;

    assign w_dc_req = dc_read | dc_write;
    // On a tie the side that did not win last time goes first.
    assign w_pick_i = ic_read & (~w_dc_req | r_last_d);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_last_d       <= 1'b1;
            r_wdog         <= '0;
            ic_done        <= 1'b0;
            ic_read_data   <= '0;
            dc_done        <= 1'b0;
            dc_read_data   <= '0;
            mmu_read       <= 1'b0;
            mmu_write      <= 1'b0;
            mmu_addr       <= '0;
            mmu_write_data <= '0;
            owner          <= 2'b00;
            timeout_err    <= 1'b0;
        end else begin
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_i) begin
                        r_state   <= ST_GRANT_I;
                        r_last_d  <= 1'b0;
                        r_wdog    <= '0;
                        mmu_read  <= 1'b1;
                        mmu_write <= 1'b0;
                        mmu_addr  <= ic_addr;
                        owner     <= 2'b01;
                    end else if (w_dc_req) begin
                        r_state        <= ST_GRANT_D;
                        r_last_d       <= 1'b1;
                        r_wdog         <= '0;
                        mmu_read       <= dc_read & ~dc_write;
                        mmu_write      <= dc_write;
                        mmu_addr       <= dc_addr;
                        mmu_write_data <= dc_write_data;
                        owner          <= 2'b10;
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    if (mmu_done) begin
                        r_state   <= ST_RELEASE;
                        mmu_read  <= 1'b0;
                        mmu_write <= 1'b0;
                        owner     <= 2'b00;
                        if (r_state == ST_GRANT_I) begin
                            ic_done      <= 1'b1;
                            ic_read_data <= mmu_read_data;
                        end else begin
                            dc_done      <= 1'b1;
                            dc_read_data <= mmu_read_data;
                        end
                    end else begin
                        // Watchdog saturates at TIMEOUT; the transaction keeps waiting.
                        if (r_wdog != WD_W'(TIMEOUT)) begin
                            r_wdog <= r_wdog + WD_W'(1);
                        end
                        if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Self-checking bench for l1_mmu_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run checked against a transaction-level model.
module tb_l1_mmu_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned TIMEOUT = 8;

    logic              sys_clk;
    logic              rst_n;
    logic              ic_read;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic [LINE_W-1:0] ic_read_data;
    logic              dc_read;
    logic              dc_write;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_done;
    logic [LINE_W-1:0] dc_read_data;
    logic              mmu_read;
    logic              mmu_write;
    logic [ADDR_W-1:0] mmu_addr;
    logic [LINE_W-1:0] mmu_write_data;
    logic              mmu_done;
    logic [LINE_W-1:0] mmu_read_data;
    logic [1:0]        owner;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    l1_mmu_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .ic_read(ic_read), .ic_addr(ic_addr), .ic_done(ic_done), .ic_read_data(ic_read_data),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_write_data(dc_write_data),
        .dc_done(dc_done), .dc_read_data(dc_read_data),
        .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
        .mmu_write_data(mmu_write_data), .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
        .owner(owner), .timeout_err(timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        icr;
        logic [31:0] ica;
        logic        dcr;
        logic        dcw;
        logic [31:0] dca;
        logic [7:0]  wb;
        logic        done;
        logic [7:0]  rb;
        logic        e_rd;
        logic        e_wr;
        logic [1:0]  e_own;
        logic [31:0] e_addr;
        logic [7:0]  e_wb;
        logic        e_icd;
        logic [7:0]  e_icb;
        logic        e_dcd;
        logic [7:0]  e_dcb;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vt[NVEC];

    function automatic vec_t mk(input logic icr, input logic [31:0] ica, input logic dcr,
                                input logic dcw, input logic [31:0] dca, input logic [7:0] wb,
                                input logic done, input logic [7:0] rb, input logic e_rd,
                                input logic e_wr, input logic [1:0] e_own, input logic [31:0] e_addr,
                                input logic [7:0] e_wb, input logic e_icd, input logic [7:0] e_icb,
                                input logic e_dcd, input logic [7:0] e_dcb);
        vec_t v;
        v.icr = icr; v.ica = ica; v.dcr = dcr; v.dcw = dcw; v.dca = dca; v.wb = wb;
        v.done = done; v.rb = rb; v.e_rd = e_rd; v.e_wr = e_wr; v.e_own = e_own;
        v.e_addr = e_addr; v.e_wb = e_wb; v.e_icd = e_icd; v.e_icb = e_icb;
        v.e_dcd = e_dcd; v.e_dcb = e_dcb;
        return v;
    endfunction

    function automatic logic [LINE_W-1:0] rep(input logic [7:0] b);
        return {(LINE_W / 8){b}};
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ic_read = 1'b0; ic_addr = '0; dc_read = 1'b0; dc_write = 1'b0; dc_addr = '0;
        dc_write_data = '0; mmu_done = 1'b0; mmu_read_data = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Random-phase model state: one outstanding transaction, owner, latched request, sticky error.
    logic              m_busy, m_cool, m_own_d, m_last_d, m_rd, m_wr, m_err, m_icd, m_dcd;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata, m_icb, m_dcb;
    int                m_wd, m_lat;

    initial begin
        logic [1:0] seq[4];
        logic [1:0] prev, o;
        logic       gap_ok;
        int         gcnt, gcyc, n;

        drive_idle();
        rst_n = 1'b0;
        tick();
        chk("reset_flags", 64'({mmu_read, mmu_write, owner, ic_done, dc_done, timeout_err, mmu_addr}), 64'd0);
        chk_line("reset_ic_data", ic_read_data, '0);
        chk_line("reset_dc_data", dc_read_data, '0);
        chk_line("reset_wdata", mmu_write_data, '0);
        tick();
        rst_n = 1'b1;

        // Directed per-cycle vectors: inputs for the next edge, outputs expected after it.
        vt[0]  = mk(1, 32'h40, 0, 0, 0, 8'h00, 0, 8'hAA, 1, 0, 2'b01, 32'h40, 8'h00, 0, 8'h00, 0, 8'h00);
        vt[1]  = mk(1, 32'h40, 0, 0, 0, 8'h00, 0, 8'hAA, 1, 0, 2'b01, 32'h40, 8'h00, 0, 8'h00, 0, 8'h00);
        vt[2]  = mk(1, 32'h40, 0, 0, 0, 8'h00, 0, 8'hAA, 1, 0, 2'b01, 32'h40, 8'h00, 0, 8'h00, 0, 8'h00);
        vt[3]  = mk(1, 32'h40, 0, 0, 0, 8'h00, 0, 8'hAA, 1, 0, 2'b01, 32'h40, 8'h00, 0, 8'h00, 0, 8'h00);
        vt[4]  = mk(1, 32'h40, 0, 0, 0, 8'h00, 1, 8'hAA, 0, 0, 2'b00, 32'h40, 8'h00, 1, 8'hAA, 0, 8'h00);
        vt[5]  = mk(0, 32'h40, 0, 0, 0, 8'h00, 0, 8'hAA, 0, 0, 2'b00, 32'h40, 8'h00, 0, 8'hAA, 0, 8'h00);
        vt[6]  = mk(0, 32'h40, 0, 0, 0, 8'h00, 1, 8'h33, 0, 0, 2'b00, 32'h40, 8'h00, 0, 8'hAA, 0, 8'h00);
        vt[7]  = mk(1, 32'h80, 0, 0, 0, 8'h00, 0, 8'h33, 1, 0, 2'b01, 32'h80, 8'h00, 0, 8'hAA, 0, 8'h00);
        vt[8]  = mk(1, 32'h80, 0, 0, 0, 8'h00, 1, 8'h33, 0, 0, 2'b00, 32'h80, 8'h00, 1, 8'h33, 0, 8'h00);
        vt[9]  = mk(0, 32'h80, 0, 0, 0, 8'h00, 0, 8'h33, 0, 0, 2'b00, 32'h80, 8'h00, 0, 8'h33, 0, 8'h00);
        vt[10] = mk(0, 32'h80, 0, 1, 32'h100, 8'h55, 0, 8'h77, 0, 1, 2'b10, 32'h100, 8'h55, 0, 8'h33, 0, 8'h00);
        vt[11] = mk(0, 32'h80, 0, 1, 32'h200, 8'h55, 0, 8'h77, 0, 1, 2'b10, 32'h100, 8'h55, 0, 8'h33, 0, 8'h00);
        vt[12] = mk(0, 32'h80, 0, 1, 32'h200, 8'h55, 0, 8'h77, 0, 1, 2'b10, 32'h100, 8'h55, 0, 8'h33, 0, 8'h00);
        vt[13] = mk(0, 32'h80, 0, 1, 32'h200, 8'h55, 1, 8'h77, 0, 0, 2'b00, 32'h100, 8'h55, 0, 8'h33, 1, 8'h77);
        vt[14] = mk(0, 32'h80, 0, 0, 32'h200, 8'h55, 0, 8'h77, 0, 0, 2'b00, 32'h100, 8'h55, 0, 8'h33, 0, 8'h77);
        vt[15] = mk(1, 32'h40, 1, 0, 32'h300, 8'h55, 0, 8'h11, 1, 0, 2'b01, 32'h40, 8'h55, 0, 8'h33, 0, 8'h77);
        vt[16] = mk(1, 32'h40, 1, 0, 32'h300, 8'h55, 1, 8'h11, 0, 0, 2'b00, 32'h40, 8'h55, 1, 8'h11, 0, 8'h77);
        vt[17] = mk(0, 32'h40, 1, 0, 32'h300, 8'h55, 0, 8'h11, 0, 0, 2'b00, 32'h40, 8'h55, 0, 8'h11, 0, 8'h77);
        vt[18] = mk(0, 32'h40, 1, 0, 32'h300, 8'h55, 0, 8'h22, 1, 0, 2'b10, 32'h300, 8'h55, 0, 8'h11, 0, 8'h77);
        vt[19] = mk(0, 32'h40, 1, 0, 32'h300, 8'h55, 1, 8'h22, 0, 0, 2'b00, 32'h300, 8'h55, 0, 8'h11, 1, 8'h22);
        vt[20] = mk(0, 32'h40, 0, 0, 32'h300, 8'h55, 0, 8'h22, 0, 0, 2'b00, 32'h300, 8'h55, 0, 8'h11, 0, 8'h22);

        for (int i = 0; i < NVEC; i++) begin
            ic_read = vt[i].icr; ic_addr = vt[i].ica; dc_read = vt[i].dcr; dc_write = vt[i].dcw;
            dc_addr = vt[i].dca; dc_write_data = rep(vt[i].wb);
            mmu_done = vt[i].done; mmu_read_data = rep(vt[i].rb);
            tick();
            chk($sformatf("vec%0d_ctl", i),
                64'({mmu_read, mmu_write, owner, ic_done, dc_done, timeout_err, mmu_addr}),
                64'({vt[i].e_rd, vt[i].e_wr, vt[i].e_own, vt[i].e_icd, vt[i].e_dcd, 1'b0, vt[i].e_addr}));
            chk_line($sformatf("vec%0d_wdata", i), mmu_write_data, rep(vt[i].e_wb));
            chk_line($sformatf("vec%0d_icdata", i), ic_read_data, rep(vt[i].e_icb));
            chk_line($sformatf("vec%0d_dcdata", i), dc_read_data, rep(vt[i].e_dcb));
        end

        // Both sides request continuously from reset; grants must alternate I, D, I, D.
        drive_idle();
        rst_n = 1'b0;
        ic_read = 1'b1; ic_addr = 32'h1000; dc_read = 1'b1; dc_addr = 32'h2000;
        tick();
        tick();
        rst_n = 1'b1;
        gcnt = 0; gcyc = 0; prev = 2'b00; gap_ok = 1'b1;
        for (int c = 0; c < 60 && gcnt < 4; c++) begin
            tick();
            o = owner;
            if (o != 2'b00 && o != prev) begin
                if (prev != 2'b00) gap_ok = 1'b0;
                seq[gcnt] = o;
                chk($sformatf("alt_addr%0d", gcnt), 64'(mmu_addr), (o == 2'b01) ? 64'h1000 : 64'h2000);
                gcnt++;
                gcyc = 0;
            end
            if (o != 2'b00) begin
                gcyc++;
                mmu_done = (gcyc == 2);
            end else begin
                mmu_done = 1'b0;
            end
            prev = o;
        end
        chk("alt_count", 64'(gcnt), 64'd4);
        chk("alt_gap", 64'(gap_ok), 64'd1);
        for (int i = 0; i < 4 && i < gcnt; i++)
            chk($sformatf("alt_order%0d", i), 64'(seq[i]), (i % 2 == 0) ? 64'd1 : 64'd2);

        // Asynchronous reset in the middle of a d-cache write.
        apply_reset();
        dc_write = 1'b1; dc_addr = 32'h500; dc_write_data = rep(8'h5A);
        n = 0;
        while (owner != 2'b10 && n < 10) begin
            tick();
            n++;
        end
        chk("rstd_grant", 64'(owner), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstd_async", 64'({mmu_write, owner, dc_done}), 64'd0);
        ic_read = 1'b1; ic_addr = 32'h640; dc_write = 1'b0; dc_read = 1'b1; dc_addr = 32'h680;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstd_tie_to_i", 64'({owner, mmu_addr}), 64'({2'b01, 32'h640}));

        // Randomized traffic against the transaction-level model.
        apply_reset();
        m_busy = 0; m_cool = 0; m_own_d = 0; m_last_d = 1; m_rd = 0; m_wr = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_icb = '0; m_dcb = '0; m_wd = 0; m_lat = 0;
        for (int c = 0; c < 2000; c++) begin
            m_icd = 0;
            m_dcd = 0;
            if (m_busy) begin
                if (mmu_done) begin
                    m_busy = 0;
                    m_cool = 1;
                    if (m_own_d) begin m_dcd = 1; m_dcb = mmu_read_data; end
                    else begin m_icd = 1; m_icb = mmu_read_data; end
                end else begin
                    if (m_wd < int'(TIMEOUT)) m_wd++;
                    if (m_wd == int'(TIMEOUT)) m_err = 1;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (ic_read || dc_read || dc_write) begin
                if (ic_read && (dc_read || dc_write)) m_own_d = !m_last_d;
                else m_own_d = !ic_read;
                m_last_d = m_own_d;
                m_busy = 1;
                m_wd = 0;
                m_lat = $urandom_range(0, 5);
                if (m_own_d) begin
                    m_addr = dc_addr; m_wdata = dc_write_data; m_wr = dc_write; m_rd = dc_read && !dc_write;
                end else begin
                    m_addr = ic_addr; m_rd = 1; m_wr = 0;
                end
            end
            tick();
            chk($sformatf("rnd%0d_ctl", c),
                64'({mmu_read, mmu_write, owner, ic_done, dc_done, timeout_err, mmu_addr}),
                64'({m_busy & m_rd, m_busy & m_wr, m_busy ? (m_own_d ? 2'b10 : 2'b01) : 2'b00,
                     m_icd, m_dcd, m_err, m_addr}));
            chk_line($sformatf("rnd%0d_wdata", c), mmu_write_data, m_wdata);
            chk_line($sformatf("rnd%0d_icdata", c), ic_read_data, m_icb);
            chk_line($sformatf("rnd%0d_dcdata", c), dc_read_data, m_dcb);

            mmu_read_data = rand_line();
            if (m_busy) begin
                mmu_done = (m_lat == 0);
                if (m_lat > 0) m_lat--;
            end else begin
                mmu_done = ($urandom_range(0, 7) == 0);
            end
            if (ic_done) ic_read = 1'b0;
            else if (!ic_read && $urandom_range(0, 2) == 0) begin
                ic_read = 1'b1;
                ic_addr = $urandom;
            end else if (ic_read && m_busy && !m_own_d && $urandom_range(0, 3) == 0) begin
                ic_addr = $urandom;
            end
            if (dc_done) begin
                dc_read = 1'b0;
                dc_write = 1'b0;
            end else if (!dc_read && !dc_write && $urandom_range(0, 2) == 0) begin
                n = $urandom_range(0, 2);
                dc_read = (n != 1);
                dc_write = (n != 0);
                dc_addr = $urandom;
                dc_write_data = rand_line();
            end
        end

        // Watchdog: grant I and withhold mmu_done.
        apply_reset();
        ic_read = 1'b1; ic_addr = 32'h7C0;
        tick();
        chk("wd_grant", 64'({owner, mmu_read}), 64'({2'b01, 1'b1}));
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("wd_cycle%0d", k), 64'({timeout_err, mmu_read}), 64'({(k >= 8) ? 1'b1 : 1'b0, 1'b1}));
        end
        mmu_done = 1'b1;
        mmu_read_data = rep(8'hC3);
        tick();
        chk("wd_done", 64'({ic_done, dc_done, timeout_err, mmu_read}), 64'({1'b1, 1'b0, 1'b1, 1'b0}));
        chk_line("wd_data", ic_read_data, rep(8'hC3));
        mmu_done = 1'b0;
        ic_read = 1'b0;
        tick();
        chk("wd_sticky", 64'({ic_done, timeout_err}), 64'({1'b0, 1'b1}));
        apply_reset();
        chk("wd_cleared", 64'(timeout_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
